// File: rtl/avg_pool_accum.sv
`default_nettype none
// ============================================================================
// Module   : avg_pool_accum
// Brief    : Global-average-pooling accumulator: per-channel saturating lane
//            sums, drained as scaled, clamped averages over valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module avg_pool_accum #(
  parameter int DATA_W   = 10,
  parameter int LANES    = 9,
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 22,
  parameter int SHIFT    = 12,
  parameter int ROUND    = 0,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_valid,
  input  logic                    i_last,
  input  logic [CH_W-1:0]         i_ch,
  input  logic [LANES*DATA_W-1:0] i_data,
  output logic                    o_in_ready,
  output logic                    o_valid,
  output logic [CH_W-1:0]         o_ch,
  output logic [DATA_W-1:0]       o_data,
  input  logic                    i_ready,
  output logic                    o_done,
  output logic                    o_ovf
);

  localparam int c_SUM_W = DATA_W + $clog2(LANES + 1);
  localparam int c_ADD_W = ((ACC_W > c_SUM_W) ? ACC_W : c_SUM_W) + 1;
  localparam logic [ACC_W-1:0]  c_ACC_MAX  = '1;
  localparam logic [DATA_W-1:0] c_DATA_MAX = '1;
  localparam logic [ACC_W:0]    c_HALF     = ((ROUND != 0) && (SHIFT > 0)) ?
      ((ACC_W+1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
  localparam logic [CH_W-1:0]   c_LAST_CH  = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [ACC_W-1:0]    r_acc [CHANNELS];
  logic                r_in_ready;
  logic                r_valid;
  logic                r_done;
  logic                r_ovf;
  logic [CH_W-1:0]     r_ch;
  logic [DATA_W-1:0]   r_data;

  logic [c_SUM_W-1:0]  w_sum;
  logic [ACC_W-1:0]    w_acc_sel;
  logic [ACC_W-1:0]    w_acc_next;
  logic [ACC_W-1:0]    w_load_acc;
  logic [c_ADD_W-1:0]  w_add;
  logic                w_ch_ok;
  logic                w_wr;
  logic                w_sat;
  logic [CH_W-1:0]     w_load_ch;
  logic [ACC_W:0]      w_rnd;
  logic [ACC_W:0]      w_shr;
  logic [DATA_W-1:0]   w_load_data;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_sum = w_sum + c_SUM_W'(i_data[k*DATA_W +: DATA_W]);
    end
  end

  assign w_ch_ok = (32'(i_ch) < 32'(CHANNELS));
  assign w_wr    = (r_state == S_ACCUM) && i_valid && w_ch_ok;

  always_comb begin
    w_acc_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (i_ch == CH_W'(c)) w_acc_sel = r_acc[c];
    end
  end

  assign w_add      = c_ADD_W'(w_acc_sel) + c_ADD_W'(w_sum);
  assign w_sat      = (w_add > c_ADD_W'(c_ACC_MAX));
  assign w_acc_next = w_sat ? c_ACC_MAX : w_add[ACC_W-1:0];

  // The result to register next: channel 0 on the last beat (which may itself
  // be updating channel 0 this cycle), otherwise the channel after o_ch.
  assign w_load_ch = (r_state == S_DRAIN) ? (r_ch + CH_W'(1)) : '0;

  always_comb begin
    w_load_acc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_load_ch == CH_W'(c)) w_load_acc = r_acc[c];
    end
    if (w_wr && (i_ch == '0)) w_load_acc = w_acc_next;
  end

  assign w_rnd       = {1'b0, w_load_acc} + c_HALF;
  assign w_shr       = w_rnd >> SHIFT;
  assign w_load_data = (w_shr > (ACC_W+1)'(c_DATA_MAX)) ? c_DATA_MAX : w_shr[DATA_W-1:0];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_ch       <= '0;
      r_data     <= '0;
      for (int c = 0; c < CHANNELS; c++) r_acc[c] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int c = 0; c < CHANNELS; c++) r_acc[c] <= '0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (i_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
              if (w_wr && (i_ch == CH_W'(c))) r_acc[c] <= w_acc_next;
            end
            if (w_wr && w_sat) r_ovf <= 1'b1;
            if (i_last) begin
              r_in_ready <= 1'b0;
              r_valid    <= 1'b1;
              r_ch       <= '0;
              r_data     <= w_load_data;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (i_ready) begin
            if (r_ch == c_LAST_CH) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_ch    <= '0;
              r_data  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_ch   <= r_ch + CH_W'(1);
              r_data <= w_load_data;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_valid    = r_valid;
  assign o_ch       = r_ch;
  assign o_data     = r_data;
  assign o_done     = r_done;
  assign o_ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_avg_pool_accum.sv
`default_nettype none
// Scoreboard bench: two instances share stimulus (A: 4 channels truncating,
// B: 3 channels rounding); per-instance monitors pop expected results.
module tb_avg_pool_accum;
  localparam int DW  = 10;
  localparam int L   = 9;
  localparam int CHW = 2;

  logic i_clk = 1'b0, i_reset = 1'b0, i_start = 1'b0, i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b0;
  logic [CHW-1:0]  i_ch   = '0;
  logic [L*DW-1:0] i_data = '0;

  logic a_in_ready, a_valid, a_done, a_ovf, b_in_ready, b_valid, b_done, b_ovf;
  logic [CHW-1:0] a_ch, b_ch;
  logic [DW-1:0]  a_data, b_data;

  avg_pool_accum #(.CHANNELS(4), .ROUND(0)) u_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid), .i_last(i_last),
    .i_ch(i_ch), .i_data(i_data), .o_in_ready(a_in_ready), .o_valid(a_valid), .o_ch(a_ch),
    .o_data(a_data), .i_ready(i_ready), .o_done(a_done), .o_ovf(a_ovf));

  avg_pool_accum #(.CHANNELS(3), .ROUND(1)) u_b (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid), .i_last(i_last),
    .i_ch(i_ch), .i_data(i_data), .o_in_ready(b_in_ready), .o_valid(b_valid), .o_ch(b_ch),
    .o_data(b_data), .i_ready(i_ready), .o_done(b_done), .o_ovf(b_ovf));

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [CHW-1:0] ch; logic [DW-1:0] d; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int checks = 0, errors = 0;
  int done_a = 0, done_b = 0;
  int rdy_mode = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pa(input int ch, input int d);
    exp_t e;
    e.ch = CHW'(ch); e.d = DW'(d);
    qa.push_back(e);
  endtask

  task automatic pb(input int ch, input int d);
    exp_t e;
    e.ch = CHW'(ch); e.d = DW'(d);
    qb.push_back(e);
  endtask

  // Monitor A
  logic a_pend = 1'b0, a_pdone = 1'b0;
  logic [CHW-1:0] a_hch;
  logic [DW-1:0]  a_hd;
  always @(negedge i_clk) begin
    exp_t e;
    if (i_reset) begin
      if (a_pend) begin
        chk("A_stall_valid", a_valid, 1); chk("A_stall_ch", a_ch, a_hch); chk("A_stall_data", a_data, a_hd);
      end
      a_pend = a_valid && !i_ready; a_hch = a_ch; a_hd = a_data;
      if (a_valid && i_ready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL A_unexpected: got ch=%0d data=%0d expected no output", a_ch, a_data);
        end else begin
          e = qa.pop_front();
          chk("A_ch", a_ch, e.ch); chk("A_data", a_data, e.d);
        end
      end
      if (a_pdone) chk("A_done_width", a_done, 0);
      if (a_done) begin done_a++; chk("A_done_q_empty", qa.size(), 0); end
      a_pdone = a_done;
    end else begin
      a_pend = 1'b0; a_pdone = 1'b0;
    end
  end

  // Monitor B
  logic b_pend = 1'b0, b_pdone = 1'b0;
  logic [CHW-1:0] b_hch;
  logic [DW-1:0]  b_hd;
  always @(negedge i_clk) begin
    exp_t e;
    if (i_reset) begin
      if (b_pend) begin
        chk("B_stall_valid", b_valid, 1); chk("B_stall_ch", b_ch, b_hch); chk("B_stall_data", b_data, b_hd);
      end
      b_pend = b_valid && !i_ready; b_hch = b_ch; b_hd = b_data;
      if (b_valid && i_ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL B_unexpected: got ch=%0d data=%0d expected no output", b_ch, b_data);
        end else begin
          e = qb.pop_front();
          chk("B_ch", b_ch, e.ch); chk("B_data", b_data, e.d);
        end
      end
      if (b_pdone) chk("B_done_width", b_done, 0);
      if (b_done) begin done_b++; chk("B_done_q_empty", qb.size(), 0); end
      b_pdone = b_done;
    end else begin
      b_pend = 1'b0; b_pdone = 1'b0;
    end
  end

  // Ready driver: mode 1 holds low for 5 cycles inside a 0/1 toggle pattern
  initial begin
    int k = 0;
    forever begin
      @(posedge i_clk); #1;
      if (rdy_mode == 0) begin
        i_ready = 1'b1; k = 0;
      end else begin
        i_ready = (k >= 3 && k < 8) ? 1'b0 : ((k % 2) == 1);
        k++;
      end
    end
  end

  function automatic logic [L*DW-1:0] fill(input int v);
    logic [L*DW-1:0] r;
    for (int k = 0; k < L; k++) r[k*DW +: DW] = DW'(v);
    return r;
  endfunction

  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  task automatic start_frame();
    i_start = 1'b1; cyc(); i_start = 1'b0;
  endtask

  task automatic beat(input int ch, input logic [L*DW-1:0] d, input logic last);
    chk("A_in_ready", a_in_ready, 1); chk("B_in_ready", b_in_ready, 1);
    i_valid = 1'b1; i_last = last; i_ch = CHW'(ch); i_data = d;
    cyc();
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_done();
    int sa = done_a, sb = done_b, n = 0;
    while ((done_a == sa || done_b == sb) && n < 300) begin cyc(); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no o_done within %0d cycles expected pulse", n);
    end
    repeat (3) cyc();
    chk("A_done_count", done_a - sa, 1); chk("B_done_count", done_b - sb, 1);
    chk("A_q_drained", qa.size(), 0);    chk("B_q_drained", qb.size(), 0);
  endtask

  task automatic scen2();
    pa(0, 0); pa(1, 2); pa(2, 3); pa(3, 0);
    pb(0, 0); pb(1, 2); pb(2, 3);
    start_frame();
    repeat (3) beat(2, fill(512), 1'b0);
    beat(1, fill(1023), 1'b1);
  endtask

  initial begin
    logic [L*DW-1:0] d;
    int n;
    #1 i_reset = 1'b0;
    repeat (3) cyc();
    chk("A_reset_outs", {a_in_ready, a_valid, a_ch, a_data, a_done, a_ovf}, 0);
    chk("B_reset_outs", {b_in_ready, b_valid, b_ch, b_data, b_done, b_ovf}, 0);
    i_reset = 1'b1;
    cyc();

    // Rounding: acc0 = 6144
    d = fill(768); d[8*DW +: DW] = '0;
    pa(0, 1); pa(1, 0); pa(2, 0); pa(3, 0);
    pb(0, 2); pb(1, 0); pb(2, 0);
    start_frame();
    beat(0, d, 1'b1);
    wait_done();
    chk("A_ovf_t1", a_ovf, 0); chk("B_ovf_t1", b_ovf, 0);

    // Multi-channel
    scen2();
    wait_done();
    chk("A_ovf_t2", a_ovf, 0); chk("B_ovf_t2", b_ovf, 0);

    // Saturation: 456 beats of 9207
    pa(0, 1023); pa(1, 0); pa(2, 0); pa(3, 0);
    pb(0, 1023); pb(1, 0); pb(2, 0);
    start_frame();
    repeat (455) beat(0, fill(1023), 1'b0);
    beat(0, fill(1023), 1'b1);
    wait_done();
    chk("A_ovf_sat", a_ovf, 1); chk("B_ovf_sat", b_ovf, 1);
    start_frame();
    chk("A_ovf_clr", a_ovf, 0); chk("B_ovf_clr", b_ovf, 0);
    pa(0, 0); pa(1, 0); pa(2, 0); pa(3, 0);
    pb(0, 0); pb(1, 0); pb(2, 0);
    beat(0, fill(0), 1'b1);
    wait_done();

    // Backpressure
    rdy_mode = 1;
    scen2();
    wait_done();
    rdy_mode = 0;
    cyc();

    // Control edges: valid/last in IDLE, start during ACCUM, out-of-range channel on B
    i_valid = 1'b1; i_last = 1'b1; i_ch = 2'd2; i_data = fill(1023);
    repeat (3) cyc();
    chk("A_idle_in_ready", a_in_ready, 0); chk("B_idle_in_ready", b_in_ready, 0);
    pa(0, 4); pa(1, 0); pa(2, 0); pa(3, 2);
    pb(0, 4); pb(1, 1); pb(2, 0);
    i_start = 1'b1; cyc(); i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    beat(0, fill(1023), 1'b0);
    beat(0, fill(1023), 1'b0);
    i_start = 1'b1; cyc(); i_start = 1'b0;
    beat(3, fill(1023), 1'b0);
    beat(1, fill(256), 1'b1);
    wait_done();
    chk("A_ovf_t5", a_ovf, 0); chk("B_ovf_t5", b_ovf, 0);

    // Reset mid-DRAIN
    pa(0, 0); pa(1, 2); pa(2, 0); pa(3, 0);
    pb(0, 0); pb(1, 2); pb(2, 0);
    start_frame();
    beat(1, fill(1023), 1'b1);
    n = 0;
    do begin @(negedge i_clk); n++; end while (!(a_valid && a_ch == 2'd1) && n < 50);
    chk("A_reach_ch1", a_valid && a_ch == 2'd1, 1);
    #2 i_reset = 1'b0;
    #1;
    chk("A_midrst_outs", {a_in_ready, a_valid, a_ch, a_data, a_done, a_ovf}, 0);
    chk("B_midrst_outs", {b_in_ready, b_valid, b_ch, b_data, b_done, b_ovf}, 0);
    qa.delete(); qb.delete();
    repeat (2) cyc();
    i_reset = 1'b1;
    cyc();
    pa(0, 0); pa(1, 0); pa(2, 1); pa(3, 0);
    pb(0, 0); pb(1, 0); pb(2, 1);
    start_frame();
    beat(2, fill(512), 1'b1);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
